// File: rtl/zsram_pkg.sv
// Shared types and constants for the zsram bank: controller states and
// same-address read/write collision policies.
package zsram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int OLD_DATA = 0;
    localparam int NEW_DATA = 1;

endpackage

// File: rtl/zsram_bank_if.sv
// Request/response bundle for the zsram bank; the clock and reset stay as
// plain ports.
interface zsram_bank_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             WriteEdge;
    logic [AW-1:0]    WriteAddr;
    logic [WIDTH-1:0] inputData;
    logic             ReadEdge;
    logic [AW-1:0]    ReadAddr;
    logic [WIDTH-1:0] outputData;
    logic             ReadValid;
    logic             Unwritten;
    logic             Busy;

    modport master (
        output WriteEdge, WriteAddr, inputData, ReadEdge, ReadAddr,
        input  outputData, ReadValid, Unwritten, Busy
    );

    modport slave (
        input  WriteEdge, WriteAddr, inputData, ReadEdge, ReadAddr,
        output outputData, ReadValid, Unwritten, Busy
    );
endinterface

// File: rtl/zsram_word.sv
// One storage word plus its written flag. Contents have no reset; they are
// zeroed only through clr_i, which takes priority over a write.
module zsram_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] data_o,
    output logic             written_o
);

    logic [WIDTH-1:0] data_q;
    logic             written_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            data_q    <= '0;
            written_q <= 1'b0;
        end else if (we_i) begin
            data_q    <= wdata_i;
            written_q <= 1'b1;
        end
    end

    assign data_o    = data_q;
    assign written_o = written_q;

endmodule

// File: rtl/zsram_bank.sv
// Word-addressed storage bank with a power-up clear sweep, 1-cycle registered
// reads and a selectable same-address read/write collision policy.
//
// state | meaning
// CLEAR | sweeping clr_cnt_q over every word; requests ignored, Busy=1
// READY | accepting writes and reads
module zsram_bank
    import zsram_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int DEPTH        = 16,
    parameter  int COLLIDE_MODE = OLD_DATA,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             Crystal50Mhz,
    input  logic             ResetN,
    input  logic             WriteEdge,
    input  logic [AW-1:0]    WriteAddr,
    input  logic [WIDTH-1:0] inputData,
    input  logic             ReadEdge,
    input  logic [AW-1:0]    ReadAddr,
    output logic [WIDTH-1:0] outputData,
    output logic             ReadValid,
    output logic             Unwritten,
    output logic             Busy
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_e           state_q;
    logic [AW-1:0]    clr_cnt_q;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             unwritten_q;

    logic [WIDTH-1:0] word_data [DEPTH];
    logic [DEPTH-1:0] word_written;

    logic             wr_ok;
    logic             collide;
    logic [WIDTH-1:0] rd_word;
    logic             rd_flag;
    logic [WIDTH-1:0] rdata_d;
    logic             unwritten_d;

    // Out-of-range write addresses (non power-of-2 DEPTH) never reach a word.
    assign wr_ok = (state_q == READY) && WriteEdge && ({1'b0, WriteAddr} < DEPTH_W);

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        zsram_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk_i    (Crystal50Mhz),
            .we_i     (wr_ok && (WriteAddr == AW'(g))),
            .clr_i    ((state_q == CLEAR) && (clr_cnt_q == AW'(g))),
            .wdata_i  (inputData),
            .data_o   (word_data[g]),
            .written_o(word_written[g])
        );
    end

    // Addresses that match no word fall through as zero data, unwritten.
    always_comb begin
        rd_word = '0;
        rd_flag = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ReadAddr == AW'(i)) begin
                rd_word = word_data[i];
                rd_flag = word_written[i];
            end
        end
    end

    assign collide     = wr_ok && (WriteAddr == ReadAddr) && (COLLIDE_MODE == NEW_DATA);
    assign rdata_d     = collide ? inputData : rd_word;
    assign unwritten_d = collide ? 1'b0 : ~rd_flag;

    always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            unwritten_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == CNT_LAST) begin
                        state_q <= READY;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + AW'(1);
                    end
                end
                READY: begin
                    if (ReadEdge) begin
                        rvalid_q    <= 1'b1;
                        rdata_q     <= rdata_d;
                        unwritten_q <= unwritten_d;
                    end
                end
            endcase
        end
    end

    assign outputData = rdata_q;
    assign ReadValid  = rvalid_q;
    assign Unwritten  = unwritten_q;
    assign Busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_zsram_bank.sv
// Directed bench for zsram_bank: three instances (old-data and new-data
// collision policy at DEPTH=16, and DEPTH=12) share one request stream.
module tb_zsram_bank;
    import zsram_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zsram_bank_if #(.WIDTH(8), .AW(4)) if_a ();
    zsram_bank_if #(.WIDTH(8), .AW(4)) if_b ();
    zsram_bank_if #(.WIDTH(8), .AW(4)) if_c ();

    assign if_b.WriteEdge = if_a.WriteEdge;
    assign if_b.WriteAddr = if_a.WriteAddr;
    assign if_b.inputData = if_a.inputData;
    assign if_b.ReadEdge  = if_a.ReadEdge;
    assign if_b.ReadAddr  = if_a.ReadAddr;
    assign if_c.WriteEdge = if_a.WriteEdge;
    assign if_c.WriteAddr = if_a.WriteAddr;
    assign if_c.inputData = if_a.inputData;
    assign if_c.ReadEdge  = if_a.ReadEdge;
    assign if_c.ReadAddr  = if_a.ReadAddr;

    zsram_bank #(.WIDTH(8), .DEPTH(16), .COLLIDE_MODE(OLD_DATA)) dut_a (
        .Crystal50Mhz(clk), .ResetN(rst_n),
        .WriteEdge(if_a.WriteEdge), .WriteAddr(if_a.WriteAddr), .inputData(if_a.inputData),
        .ReadEdge(if_a.ReadEdge), .ReadAddr(if_a.ReadAddr),
        .outputData(if_a.outputData), .ReadValid(if_a.ReadValid),
        .Unwritten(if_a.Unwritten), .Busy(if_a.Busy)
    );

    zsram_bank #(.WIDTH(8), .DEPTH(16), .COLLIDE_MODE(NEW_DATA)) dut_b (
        .Crystal50Mhz(clk), .ResetN(rst_n),
        .WriteEdge(if_b.WriteEdge), .WriteAddr(if_b.WriteAddr), .inputData(if_b.inputData),
        .ReadEdge(if_b.ReadEdge), .ReadAddr(if_b.ReadAddr),
        .outputData(if_b.outputData), .ReadValid(if_b.ReadValid),
        .Unwritten(if_b.Unwritten), .Busy(if_b.Busy)
    );

    zsram_bank #(.WIDTH(8), .DEPTH(12), .COLLIDE_MODE(OLD_DATA)) dut_c (
        .Crystal50Mhz(clk), .ResetN(rst_n),
        .WriteEdge(if_c.WriteEdge), .WriteAddr(if_c.WriteAddr), .inputData(if_c.inputData),
        .ReadEdge(if_c.ReadEdge), .ReadAddr(if_c.ReadAddr),
        .outputData(if_c.outputData), .ReadValid(if_c.ReadValid),
        .Unwritten(if_c.Unwritten), .Busy(if_c.Busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_a.WriteEdge = 1'b0;
        if_a.ReadEdge  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        if_a.WriteEdge = 1'b1;
        if_a.WriteAddr = a;
        if_a.inputData = d;
    endtask

    task automatic rd(input logic [3:0] a);
        if_a.ReadEdge = 1'b1;
        if_a.ReadAddr = a;
    endtask

    // Edge index (1-based, after release) at which each Busy first reads low;
    // 0 means it never fell within the budget.
    task automatic count_busy(output int fa, output int fb, output int fc,
                              output logic rv_seen, input int drop_at);
        fa = 0; fb = 0; fc = 0;
        rv_seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            rv_seen = rv_seen | if_a.ReadValid | if_b.ReadValid | if_c.ReadValid;
            if (fa == 0 && !if_a.Busy) fa = n;
            if (fb == 0 && !if_b.Busy) fb = n;
            if (fc == 0 && !if_c.Busy) fc = n;
            if (n == drop_at) if_a.ReadEdge = 1'b0;
            if (fa != 0 && fb != 0 && fc != 0) break;
        end
    endtask

    initial begin
        int   fa, fb, fc;
        logic rv_seen;

        idle();
        if_a.WriteAddr = '0;
        if_a.ReadAddr  = '0;
        if_a.inputData = '0;
        rst_n = 1'b0;
        #12;
        check("rst_busy_a", 32'(if_a.Busy), 32'd1);
        check("rst_rv_a",   32'(if_a.ReadValid), 32'd0);
        check("rst_out_a",  32'(if_a.outputData), 32'h00);
        check("rst_unw_a",  32'(if_a.Unwritten), 32'd0);
        check("rst_busy_c", 32'(if_c.Busy), 32'd1);

        // Read address 3 held during the clear sweep must be ignored
        rd(4'd3);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(fa, fb, fc, rv_seen, 10);
        check("busy_len_a", 32'(fa), 32'd16);
        check("busy_len_b", 32'(fb), 32'd16);
        check("busy_len_c", 32'(fc), 32'd12);
        check("rv_in_clear", 32'(rv_seen), 32'd0);
        idle();

        wr(4'd5, 8'hA5); step(); idle();
        rd(4'd6); step();
        check("rd6_out", 32'(if_a.outputData), 32'h00);
        check("rd6_rv",  32'(if_a.ReadValid), 32'd1);
        check("rd6_unw", 32'(if_a.Unwritten), 32'd1);
        rd(4'd5); step();
        check("rd5_out", 32'(if_a.outputData), 32'hA5);
        check("rd5_rv",  32'(if_a.ReadValid), 32'd1);
        check("rd5_unw", 32'(if_a.Unwritten), 32'd0);
        idle(); step();
        check("hold_rv",  32'(if_a.ReadValid), 32'd0);
        check("hold_out", 32'(if_a.outputData), 32'hA5);
        check("hold_unw", 32'(if_a.Unwritten), 32'd0);

        wr(4'd7, 8'h11); step(); idle();
        wr(4'd7, 8'h22); rd(4'd7); step(); idle();
        check("coll7_old",     32'(if_a.outputData), 32'h11);
        check("coll7_new",     32'(if_b.outputData), 32'h22);
        check("coll7_old_unw", 32'(if_a.Unwritten), 32'd0);
        check("coll7_new_unw", 32'(if_b.Unwritten), 32'd0);
        wr(4'd9, 8'h33); rd(4'd9); step(); idle();
        check("coll9_old",     32'(if_a.outputData), 32'h00);
        check("coll9_old_unw", 32'(if_a.Unwritten), 32'd1);
        check("coll9_new",     32'(if_b.outputData), 32'h33);
        check("coll9_new_unw", 32'(if_b.Unwritten), 32'd0);
        wr(4'd10, 8'h44); rd(4'd7); step(); idle();
        check("rd7_after_a", 32'(if_a.outputData), 32'h22);
        check("rd7_after_b", 32'(if_b.outputData), 32'h22);
        check("rd7_rv",      32'(if_a.ReadValid), 32'd1);
        rd(4'd10); step(); idle();
        check("rd10_out", 32'(if_a.outputData), 32'h44);
        check("rd10_unw", 32'(if_a.Unwritten), 32'd0);

        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 8'(i)); step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            rd(4'(i)); step();
            check("seq_rv",  32'(if_a.ReadValid), 32'd1);
            check("seq_out", 32'(if_a.outputData), 32'(i));
        end
        idle(); step();
        check("seq_end_rv",  32'(if_a.ReadValid), 32'd0);
        check("seq_end_out", 32'(if_a.outputData), 32'h0F);

        wr(4'd13, 8'hFF); step(); idle();
        for (int i = 0; i < 12; i++) begin
            rd(4'(i)); step();
            check("d12_word", 32'(if_c.outputData), 32'(i));
            check("d12_unw",  32'(if_c.Unwritten), 32'd0);
        end
        rd(4'd13); step(); idle();
        check("d12_oor_out", 32'(if_c.outputData), 32'h00);
        check("d12_oor_unw", 32'(if_c.Unwritten), 32'd1);
        check("d12_oor_rv",  32'(if_c.ReadValid), 32'd1);
        check("d16_rd13",    32'(if_a.outputData), 32'hFF);

        // Asynchronous reset lands mid-cycle while a read result is valid
        rd(4'd5); step(); idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rv",   32'(if_a.ReadValid), 32'd0);
        check("arst_out",  32'(if_a.outputData), 32'h00);
        check("arst_busy", 32'(if_a.Busy), 32'd1);
        check("arst_unw",  32'(if_a.Unwritten), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("midclr_busy", 32'(if_a.Busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(fa, fb, fc, rv_seen, 0);
        check("rebusy_len_a", 32'(fa), 32'd16);
        check("rebusy_len_b", 32'(fb), 32'd16);
        check("rebusy_len_c", 32'(fc), 32'd12);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i)); step();
            check("clr_out", 32'(if_a.outputData), 32'h00);
            check("clr_unw", 32'(if_a.Unwritten), 32'd1);
            check("clr_rv",  32'(if_a.ReadValid), 32'd1);
        end
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
